// File: rtl/vic_vram_responder.sv
// Video/CPU front end for the single-port video RAM: a two-entry address cache frees RAM slots for the CPU.
// Optional starvation guard: define VRAM_STARVE_GUARD_EN.
module vic_vram_responder
`ifdef VRAM_STARVE_GUARD_EN
#(
    parameter int STARVE_LIMIT = 15
)
`endif
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] vga_addr,
    output logic [7:0]  vga_data,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        vid_underrun
);

    logic [1:0]       valid;
    logic [1:0][15:0] tag;
    logic [1:0][7:0]  data;
    logic             lru;
    logic             fill_pend;
    logic [15:0]      fill_tag;
    logic [7:0]       vga_q;
    logic [7:0]       rdata_q;
    logic             ack_rd_q;

    logic [1:0]       hit_e;
    logic             hit_f;
    logic             hit;
    logic             hit_idx;
    logic [7:0]       hit_data;
    logic             force_grant;
    logic             grant;
    logic             vid_skip;
    logic             wr;

    // The entry being refilled this cycle is not hittable: its old contents are on their way out.
    always_comb begin
        hit_e = '0;
        for (int i = 0; i < 2; i++)
            hit_e[i] = valid[i] && (tag[i] == vga_addr) && !(fill_pend && (lru == 1'(i)));
        hit_f    = fill_pend && (fill_tag == vga_addr);
        hit      = hit_f || (|hit_e);
        hit_idx  = hit_f ? lru : hit_e[1];
        hit_data = hit_f ? mem_rdata : (hit_e[1] ? data[1] : data[0]);
    end

`ifdef VRAM_STARVE_GUARD_EN
    logic [3:0] starve_cnt;

    assign force_grant = (starve_cnt == 4'(STARVE_LIMIT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            starve_cnt <= '0;
        else if (grant)
            starve_cnt <= '0;
        else if (cpu_req && !force_grant)
            starve_cnt <= starve_cnt + 4'd1;
    end
`else
    assign force_grant = 1'b0;
`endif

    // Ack cycle is never grantable, so back-to-back requests get at most one slot per two cycles.
    assign grant    = cpu_req && !cpu_ack && (hit || force_grant);
    assign vid_skip = grant && !hit;
    assign wr       = grant && cpu_we;

    assign mem_addr  = grant ? cpu_addr : vga_addr;
    assign mem_we    = wr;
    assign mem_wdata = cpu_wdata;

    assign vga_data  = fill_pend ? mem_rdata : vga_q;
    assign cpu_rdata = ack_rd_q ? mem_rdata : rdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid        <= '0;
            tag          <= '0;
            data         <= '0;
            lru          <= 1'b0;
            fill_pend    <= 1'b0;
            fill_tag     <= '0;
            vga_q        <= '0;
            rdata_q      <= '0;
            ack_rd_q     <= 1'b0;
            cpu_ack      <= 1'b0;
            vid_underrun <= 1'b0;
        end else begin
            // A skipped video slot keeps showing whatever vga_data currently shows.
            vga_q        <= hit ? hit_data : vga_data;
            fill_pend    <= !hit && !vid_skip;
            fill_tag     <= vga_addr;
            cpu_ack      <= grant;
            ack_rd_q     <= grant && !cpu_we;
            rdata_q      <= cpu_rdata;
            vid_underrun <= vid_skip;

            for (int i = 0; i < 2; i++)
                if (wr && valid[i] && (tag[i] == cpu_addr))
                    data[i] <= cpu_wdata;

            // Fill lands after write-through; a same-address CPU write supplies the newer byte.
            if (fill_pend) begin
                valid[lru] <= 1'b1;
                tag[lru]   <= fill_tag;
                data[lru]  <= (wr && (cpu_addr == fill_tag)) ? cpu_wdata : mem_rdata;
            end

            if (hit)
                lru <= !hit_idx;
            else if (fill_pend)
                lru <= !lru;
        end
    end

endmodule
